slave_mem_responder: RTL and testbench

//  Memory-backed target for one crossbar slave port; sits directly downstream of the crossbar.

---
 rtl/xbar_pkg.sv | 19 +
 rtl/slave_mem_responder_if.sv | 25 ++
 rtl/slave_mem_array.sv | 29 ++
 rtl/slave_mem_responder.sv | 123 ++++++++++++
 tb/tb_slave_mem_responder.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/xbar_pkg.sv
// Shared crossbar definitions: data width, command encoding, out-of-range read
// pattern and the slave responder state type.
package xbar_pkg;

   localparam int DW = 32;

   localparam logic CMD_RD = 1'b0;
   localparam logic CMD_WR = 1'b1;

   localparam logic [DW-1:0] OOR_PATTERN = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {
      IDLE,
      ACK,
      WAIT,
      RESP
   } state_t;

endpackage

// File: rtl/slave_mem_responder_if.sv
// Request/response bus between one crossbar slave port and its memory target.
interface slave_mem_responder_if #(
   parameter int AW = 30
);
   import xbar_pkg::*;

   logic          req;
   logic          cmd;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic          ack;
   logic          resp;
   logic [DW-1:0] rdata;

   modport master (
      output req, cmd, addr, wdata,
      input  ack, resp, rdata
   );

   modport slave (
      input  req, cmd, addr, wdata,
      output ack, resp, rdata
   );

endinterface

// File: rtl/slave_mem_array.sv
// DEPTH x DW storage with one registered read port and one write port.
// No reset: contents survive reset of the surrounding responder.
module slave_mem_array
   import xbar_pkg::*;
#(
   parameter  int DEPTH = 256,
   localparam int IW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rd_en,
   input  logic [IW-1:0] rd_idx,
   output logic [DW-1:0] rd_data,
   input  logic          wr_en,
   input  logic [IW-1:0] wr_idx,
   input  logic [DW-1:0] wr_data
);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_idx] <= wr_data;
      end
      if (rd_en) begin
         rd_data <= mem[rd_idx];
      end
   end

endmodule

// File: rtl/slave_mem_responder.sv
// Memory-backed crossbar slave: one transaction at a time, programmable service latency.
// Optional build macro SLAVE_OOR_CHECK_EN turns on out-of-range address detection.
//
//   state | meaning
//   IDLE  | waiting for req; fields captured on the accepting edge
//   ACK   | ack pulse; wait counter loaded
//   WAIT  | WAIT_CYCLES idle cycles counted down
//   RESP  | resp pulse; rdata valid for reads, write committed on exit
module slave_mem_responder
   import xbar_pkg::*;
#(
   parameter int N           = 4,
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 2
) (
   input logic                 clk,
   input logic                 rst_n,
   slave_mem_responder_if.slave bus
);

   localparam int         AW        = 32 - $clog2(N);
   localparam int         IW        = $clog2(DEPTH);
   localparam logic [7:0] WAIT_INIT = 8'(WAIT_CYCLES);

   state_t        state;
   state_t        state_nxt;
   logic [7:0]    cnt;
   logic          capture;
   logic          cmd_q;
   logic [IW-1:0] idx_q;
   logic [DW-1:0] wdata_q;
   logic [DW-1:0] rdata_q;
   logic [DW-1:0] rd_word;
   logic          addr_hi;
   logic          oor;
   logic          wr_en;

   assign capture = (state == IDLE) && bus.req;
   assign addr_hi = (bus.addr >> IW) != '0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (bus.req) state_nxt = ACK;
         ACK:  state_nxt = (WAIT_INIT != 8'd0) ? WAIT : RESP;
         WAIT: if (cnt == 8'd1) state_nxt = RESP;
         RESP: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= 8'd0;
      end else if (state == ACK) begin
         cnt <= WAIT_INIT;
      end else if (state == WAIT) begin
         cnt <= cnt - 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (capture) begin
         cmd_q   <= bus.cmd;
         idx_q   <= bus.addr[IW-1:0];
         wdata_q <= bus.wdata;
      end
   end

`ifdef SLAVE_OOR_CHECK_EN
   logic oor_q;

   always_ff @(posedge clk) begin
      if (capture) begin
         oor_q <= addr_hi;
      end
   end

   assign oor = oor_q;
`else
   // Upper address bits alias modulo DEPTH in this build.
   logic unused_addr_hi;
   assign unused_addr_hi = addr_hi;
   assign oor            = 1'b0;
`endif

   // Array read is launched on the accepting edge so the word is ready by the
   // edge entering RESP, even with zero wait cycles.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else if ((state_nxt == RESP) && (state != RESP) && (cmd_q == CMD_RD)) begin
         rdata_q <= oor ? OOR_PATTERN : rd_word;
      end
   end

   assign wr_en = (state == RESP) && (cmd_q == CMD_WR) && !oor && rst_n;

   slave_mem_array #(
      .DEPTH (DEPTH)
   ) u_mem (
      .clk     (clk),
      .rd_en   (capture),
      .rd_idx  (bus.addr[IW-1:0]),
      .rd_data (rd_word),
      .wr_en   (wr_en),
      .wr_idx  (idx_q),
      .wr_data (wdata_q)
   );

   assign bus.ack   = (state == ACK);
   assign bus.resp  = (state == RESP);
   assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_slave_mem_responder.sv
// Bench for slave_mem_responder: two instances (WAIT_CYCLES=2 and 0) checked
// against an array-based memory model and cycle-count latency rules.
module tb_slave_mem_responder;
   import xbar_pkg::*;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   slave_mem_responder_if #(.AW(30)) bus2 ();
   slave_mem_responder_if #(.AW(30)) bus0 ();

   slave_mem_responder #(.N(4), .DEPTH(256), .WAIT_CYCLES(2)) dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus2)
   );

   slave_mem_responder #(.N(4), .DEPTH(256), .WAIT_CYCLES(0)) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: index 0 is the 2-wait instance, index 1 the 0-wait one.
   logic [31:0] mmem [2][256];
   logic [31:0] last [2];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int waits(input int sel);
      return (sel == 1) ? 0 : 2;
   endfunction

   function automatic logic get_ack(input int sel);
      return (sel == 1) ? bus0.ack : bus2.ack;
   endfunction

   function automatic logic get_resp(input int sel);
      return (sel == 1) ? bus0.resp : bus2.resp;
   endfunction

   function automatic logic [31:0] get_rdata(input int sel);
      return (sel == 1) ? bus0.rdata : bus2.rdata;
   endfunction

   function automatic logic [31:0] exp_read(input int sel, input logic [29:0] a);
`ifdef SLAVE_OOR_CHECK_EN
      if (a >= 30'd256) return 32'hDEAD_BEEF;
`endif
      return mmem[sel][int'(a % 30'd256)];
   endfunction

   task automatic model_write(input int sel, input logic [29:0] a, input logic [31:0] wd);
`ifdef SLAVE_OOR_CHECK_EN
      if (a >= 30'd256) return;
`endif
      mmem[sel][int'(a % 30'd256)] = wd;
   endtask

   task automatic drive(input int sel, input logic r, input logic c,
                        input logic [29:0] a, input logic [31:0] wd);
      if (sel == 1) begin
         bus0.req = r; bus0.cmd = c; bus0.addr = a; bus0.wdata = wd;
      end else begin
         bus2.req = r; bus2.cmd = c; bus2.addr = a; bus2.wdata = wd;
      end
   endtask

   // Raises req at the current negedge and counts negedges until resp.
   task automatic txn(input int sel, input logic c, input logic [29:0] a,
                      input logic [31:0] wd, input int exp_ack, input bit hold,
                      input bit idle_chk, input string tag, output logic [31:0] rd);
      int n      = 0;
      int n_ack  = 0;
      int n_resp = 0;
      int ack_at  = -1;
      int resp_at = -1;
      rd = 'x;
      drive(sel, 1'b1, c, a, wd);
      while (n_resp == 0 && n < 40) begin
         @(negedge clk);
         n++;
         if (get_ack(sel)) begin
            n_ack++;
            if (ack_at < 0) ack_at = n;
         end
         if (get_resp(sel)) begin
            n_resp++;
            resp_at = n;
            rd = get_rdata(sel);
         end
         if (ack_at >= 0 && (!hold || n > ack_at)) drive(sel, 1'b0, c, a, wd);
      end
      drive(sel, 1'b0, c, a, wd);
      check({tag, "_ack_cycle"}, ack_at, exp_ack);
      check({tag, "_resp_cycle"}, resp_at, exp_ack + 1 + waits(sel));
      check({tag, "_ack_count"}, n_ack, 1);
      if (idle_chk) begin
         n_ack  = 0;
         n_resp = 0;
         repeat (3) begin
            @(negedge clk);
            if (get_ack(sel)) n_ack++;
            if (get_resp(sel)) n_resp++;
         end
         check({tag, "_idle_ack"}, n_ack, 0);
         check({tag, "_idle_resp"}, n_resp, 0);
      end
   endtask

   task automatic op(input int sel, input logic c, input logic [29:0] a,
                     input logic [31:0] wd, input int exp_ack, input bit hold,
                     input bit idle_chk, input string tag);
      logic [31:0] rd;
      logic [31:0] exp;
      if (exp_ack == 1) @(negedge clk);
      exp = (c == CMD_RD) ? exp_read(sel, a) : last[sel];
      txn(sel, c, a, wd, exp_ack, hold, idle_chk, tag, rd);
      check({tag, "_rdata"}, rd, exp);
      if (c == CMD_RD) last[sel] = exp;
      else model_write(sel, a, wd);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int sel;
      int n_resp;
      logic c;
      logic [29:0] a;
      logic [31:0] wd;

      rst_n = 1'b0;
      drive(0, 1'b0, CMD_RD, '0, '0);
      drive(1, 1'b0, CMD_RD, '0, '0);
      last[0] = '0;
      last[1] = '0;
      repeat (3) @(negedge clk);
      check("rst_ack2", bus2.ack, 1'b0);
      check("rst_resp2", bus2.resp, 1'b0);
      check("rst_rdata2", bus2.rdata, 32'h0);
      check("rst_ack0", bus0.ack, 1'b0);
      check("rst_resp0", bus0.resp, 1'b0);
      check("rst_rdata0", bus0.rdata, 32'h0);
      rst_n = 1'b1;

      for (int s = 0; s < 2; s++)
         for (int i = 0; i < 33; i++)
            op(s, CMD_WR, 30'(i), $urandom, 1, 1'b0, 1'b0, "init");

      // Write then read back, 2-wait latency.
      op(0, CMD_WR, 30'h10, 32'h1234_5678, 1, 1'b0, 1'b0, "wr10");
      op(0, CMD_RD, 30'h10, 32'h0, 1, 1'b0, 1'b0, "rd10");

      // Zero-wait read followed by back-to-back requests.
      op(1, CMD_RD, 30'h0, 32'h0, 1, 1'b0, 1'b0, "w0_rd0");
      op(1, CMD_WR, 30'h3, 32'hCAFE_0003, 2, 1'b0, 1'b0, "b2b_wr");
      op(1, CMD_RD, 30'h3, 32'h0, 2, 1'b0, 1'b0, "b2b_rd");
      op(1, CMD_RD, 30'h7, 32'h0, 2, 1'b0, 1'b1, "b2b_rd2");

      // req held through the ack cycle.
      op(0, CMD_WR, 30'h11, 32'h0BAD_F00D, 1, 1'b1, 1'b1, "hold_wr");
      op(0, CMD_RD, 30'h11, 32'h0, 1, 1'b1, 1'b1, "hold_rd");
      op(1, CMD_RD, 30'h11, 32'h0, 1, 1'b1, 1'b1, "hold_rd_w0");

      // Aliasing / out-of-range.
      op(0, CMD_WR, 30'h005, 32'h5555_0005, 1, 1'b0, 1'b0, "pre005");
      op(0, CMD_WR, 30'h105, 32'hA5A5_A5A5, 1, 1'b0, 1'b0, "wr105");
      op(0, CMD_RD, 30'h005, 32'h0, 1, 1'b0, 1'b0, "rd005");
      op(0, CMD_RD, 30'h105, 32'h0, 1, 1'b0, 1'b0, "rd105");

      // Read, intervening write elsewhere, rdata must hold.
      op(0, CMD_RD, 30'h8, 32'h0, 1, 1'b0, 1'b0, "rd8");
      op(0, CMD_WR, 30'h9, 32'h9999_0009, 1, 1'b0, 1'b0, "wr9_hold");
      op(0, CMD_RD, 30'h9, 32'h0, 1, 1'b0, 1'b0, "rd9");

      // Reset during WAIT drops the in-flight write.
      op(0, CMD_WR, 30'h20, 32'h1111_1111, 1, 1'b0, 1'b0, "pre20");
      op(0, CMD_RD, 30'h20, 32'h0, 1, 1'b0, 1'b0, "rd20a");
      @(negedge clk);
      drive(0, 1'b1, CMD_WR, 30'h20, 32'h2222_2222);
      @(negedge clk);
      check("rstw_ack", bus2.ack, 1'b1);
      drive(0, 1'b0, CMD_WR, 30'h20, 32'h2222_2222);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("rstw_ack_low", bus2.ack, 1'b0);
      check("rstw_resp_low", bus2.resp, 1'b0);
      check("rstw_rdata_zero", bus2.rdata, 32'h0);
      last[0] = '0;
      last[1] = '0;
      n_resp = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus2.resp) n_resp++;
      end
      check("rstw_no_resp", n_resp, 0);
      op(0, CMD_RD, 30'h20, 32'h0, 1, 1'b0, 1'b0, "rd20b");

      // Randomized traffic against the model.
      for (int i = 0; i < 60; i++) begin
         sel = int'($urandom_range(0, 1));
         c   = 1'($urandom_range(0, 1));
         a   = 30'($urandom_range(0, 31));
         if ($urandom_range(0, 3) == 0) a = a + 30'($urandom_range(1, 3) * 256);
         wd  = $urandom;
         op(sel, c, a, wd, 1, 1'($urandom_range(0, 1)), 1'b0, "rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
